// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: eight-way round-robin arbiter that owns the select lines
// of a shared 3-to-8 one-hot decoder. One owner at a time; the owner's index
// drives the decoder and the one-hot grant. A hold limit forces rotation when
// other requesters are waiting, so no requester can monopolise the path.
module decoder_rr_arbiter #(
   parameter  int MAX_HOLD = 16,
   localparam int HW       = $clog2(MAX_HOLD)
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   logic [0:0]    state;
   logic [2:0]    last_idx;
   logic [HW-1:0] hold_cnt;

   logic [7:0]    cand;
   logic [2:0]    off;
   logic [2:0]    win_idx;
   logic          win_vld;
   logic          at_limit;

   // Search the candidates (owner masked out while granted) starting just past last_idx.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      cand    = req;
      off     = 3'd0;
      win_idx = last_idx;
      win_vld = 1'b0;
      if (state == ST_GRANT) begin
         cand[gnt_idx] = 1'b0;
      end
      // Offsets 1..8; the 3-bit wrap makes offset 8 land on last_idx itself.
      for (int i = 1; i <= 8; i++) begin
         off = last_idx + 3'(i);
         if (!win_vld && cand[off]) begin
            win_vld = 1'b1;
            win_idx = off;
         end
      end
      at_limit = (hold_cnt == HOLD_LAST);
   end

   // Grant state machine: new grants, handovers, forced rotation and hold counting.
   always_ff @(posedge sys_clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         gnt      <= 8'h00;
         gnt_idx  <= 3'd0;
         gnt_vld  <= 1'b0;
         hold_cnt <= '0;
         last_idx <= 3'd7;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  state    <= ST_GRANT;
                  gnt      <= 8'b1 << win_idx;
                  gnt_idx  <= win_idx;
                  gnt_vld  <= 1'b1;
                  hold_cnt <= '0;
                  last_idx <= win_idx;
               end
            end
            default: begin
               if (!req[gnt_idx] || (at_limit && win_vld)) begin
                  // Owner released or hit the limit: hand over directly when someone else waits.
                  if (win_vld) begin
                     gnt      <= 8'b1 << win_idx;
                     gnt_idx  <= win_idx;
                     hold_cnt <= '0;
                     last_idx <= win_idx;
                  end else begin
                     state    <= ST_IDLE;
                     gnt      <= 8'h00;
                     gnt_vld  <= 1'b0;
                     hold_cnt <= '0;
                  end
               end else if (!at_limit) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
               // At the limit with nobody else waiting, the count simply stays saturated.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed and randomized bench for decoder_rr_arbiter (MAX_HOLD = 16).
module tb_decoder_rr_arbiter;

   localparam int MAX_HOLD = 16;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] req       = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic m_vld;
   int   m_idx;
   int   m_last;
   int   m_hold;

   decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_vld   (gnt_vld)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic expect_grant(input string tag, input int idx);
      logic [7:0] one;
      one = 8'h01;
      check({tag, ".gnt"},     32'(gnt),     32'(one << idx));
      check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(idx));
      check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'd1);
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".gnt"},     32'(gnt),     32'h0);
      check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'd0);
   endtask

   function automatic int pick(input logic [7:0] r, input int last, input int excl);
      for (int k = 1; k <= 8; k++) begin
         int j;
         j = (last + k) % 8;
         if (j != excl && r[j]) return j;
      end
      return -1;
   endfunction

   // Reference model: next state for one edge given reset and req.
   task automatic model_step(input logic rstn, input logic [7:0] r);
      int w;
      w = -1;
      if (!rstn) begin
         m_vld = 1'b0; m_idx = 0; m_last = 7; m_hold = 0;
      end else if (!m_vld) begin
         w = pick(r, m_last, -1);
      end else if (!r[m_idx]) begin
         w = pick(r, m_last, m_idx);
         if (w < 0) m_vld = 1'b0;
      end else if (m_hold == MAX_HOLD - 1) begin
         w = pick(r, m_last, m_idx);
      end else begin
         m_hold++;
      end
      if (w >= 0) begin
         m_vld = 1'b1; m_idx = w; m_last = w; m_hold = 0;
      end
   endtask

   initial begin
      logic [7:0] one;
      logic [7:0] exp_gnt;
      logic [7:0] wait_gnt;
      int         waitrun;
      one      = 8'h01;
      wait_gnt = 8'h00;
      waitrun  = 0;

      // Reset with all requests high: outputs stay cleared.
      sys_rst_n = 1'b0;
      req       = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_idle("rst");
         check("rst.gnt_idx", 32'(gnt_idx), 32'd0);
      end

      // Release with no requests: idle.
      sys_rst_n = 1'b1;
      req       = 8'h00;
      tick();
      expect_idle("idle");
      check("idle.gnt_idx", 32'(gnt_idx), 32'd0);

      // First grant: requester 0 after one edge.
      req = 8'h01;
      tick();
      expect_grant("first", 0);

      // Round robin: each owner drops its request for one edge.
      for (int i = 0; i < 8; i++) begin
         req = 8'hFF & ~(one << i);
         tick();
         expect_grant("rr", (i + 1) % 8);
      end

      // Hold limit with req=09: owner 0 (one cycle already seen) holds 16, then 3 for 16, then 0.
      req = 8'h09;
      for (int k = 2; k <= 16; k++) begin
         tick();
         expect_grant("hold0", 0);
      end
      check("hold0.cnt", 32'(dut.hold_cnt), 32'd15);
      tick();
      expect_grant("rot3", 3);
      for (int k = 2; k <= 16; k++) begin
         tick();
         expect_grant("hold3", 3);
      end
      tick();
      expect_grant("rot0", 0);

      // Lone requester: holds indefinitely, counter saturates.
      req = 8'h01;
      for (int k = 0; k < 20; k++) begin
         tick();
         expect_grant("sat", 0);
      end
      check("sat.cnt", 32'(dut.hold_cnt), 32'd15);

      // Handover to 6, then 6 drops with req=05: search wraps 7 -> 0.
      req = 8'h40;
      tick();
      expect_grant("to6", 6);
      req = 8'h05;
      tick();
      expect_grant("wrap", 0);

      // Hand to 5, then reset mid-grant.
      req = 8'h20;
      tick();
      expect_grant("to5", 5);
      sys_rst_n = 1'b0;
      req       = 8'hFF;
      tick();
      expect_idle("midrst");
      check("midrst.gnt_idx", 32'(gnt_idx), 32'd0);
      sys_rst_n = 1'b1;
      tick();
      expect_grant("postrst", 0);

      // Non-owner changes do not disturb the owner below the limit.
      req = 8'h81;
      tick();
      expect_grant("noneown_a", 0);
      req = 8'h03;
      tick();
      expect_grant("noneown_b", 0);

      // Randomized phase against the reference model, aligned by a reset edge.
      sys_rst_n = 1'b0;
      model_step(1'b0, req);
      tick();
      sys_rst_n = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 3) == 0) req = 8'($urandom);
         else if ($urandom_range(0, 7) == 0) req = req & ~gnt;
         // Streak of cycles the current owner holds while someone else is waiting.
         if (gnt_vld && ((req & ~gnt) != 8'h00)) begin
            waitrun  = (gnt == wait_gnt) ? waitrun + 1 : 1;
            wait_gnt = gnt;
         end else begin
            waitrun  = 0;
            wait_gnt = 8'h00;
         end
         check("rand.holdlimit", 32'(waitrun <= MAX_HOLD), 32'd1);
         model_step(1'b1, req);
         tick();
         exp_gnt = m_vld ? (one << m_idx) : 8'h00;
         check("rand.model", {23'd0, gnt_vld, gnt}, {23'd0, m_vld, exp_gnt});
         check("rand.decode", 32'(gnt), 32'(gnt_vld ? (one << gnt_idx) : 8'h00));
         check("rand.reqlow", 32'(gnt & ~req), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares the 3-to-8 one-hot decoder output path among eight requesters. Each cycle it picks one owner, drives that owner's 3-bit index to the decoder select inputs, and presents the matching one-hot grant. A hold limit stops any single requester from monopolising the path. It sits between the requester logic and the decoder and sequences all decoder select changes.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles for one owner while another requester waits. Legal range is 2..256.
- HW, $clog2(MAX_HOLD): width of the hold counter. Derived; not overridden.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  reset, synchronous and active-low.
- req  in  8  request vector; bit i is requester i. Level-sensitive.
- gnt  out  8  one-hot grant, registered. Equals 1<<gnt_idx when gnt_vld=1, else 0.
- gnt_idx  out  3  registered owner index, {in1,in2,in3} order for the decoder (MSB first).
- gnt_vld  out  1  registered; high while a grant is held.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: owner = gnt_idx.
- Priority pointer last_idx:
  - Search order starts at last_idx+1 and runs modulo 8.
  - The first set bit in that order wins.
  - last_idx updates to the winner on every new grant.
- IDLE:
  - If req != 0, take the search winner and go to GRANT.
  - Set hold_cnt=0 on entry.
  - If req == 0, stay in IDLE.
- GRANT, owner request low (req[gnt_idx]=0):
  - Release the grant.
  - In the same edge, search the remaining requests, excluding the owner.
  - If a winner exists, grant it directly with no idle cycle and set hold_cnt=0.
  - Otherwise go to IDLE.
- GRANT, owner request still high:
  - If hold_cnt == MAX_HOLD-1 and any other req bit is set, force a rotation to the search winner that excludes the owner, and set hold_cnt=0.
  - If no other request is set, keep the grant and saturate hold_cnt at MAX_HOLD-1.
  - Otherwise hold_cnt increments by 1.
- Invariants:
  - gnt is always 0 or exactly one-hot.
  - gnt never goes to a requester whose req bit was low at the deciding edge.
  - Changing req bits of non-owners never disturbs the current grant until the hold limit is reached.
- Fairness: if all 8 requesters assert continuously, each is granted exactly once per 8*MAX_HOLD cycles, in index order.

## Timing
- Reset (sys_rst_n=0 sampled at an edge):
  - gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, state=IDLE.
  - hold_cnt=0, last_idx=3'd7, so requester 0 has top priority first.
- Reset mid-grant: the grant drops at that same edge; there is no drain.
- Grant latency: req sampled at edge n produces gnt/gnt_idx/gnt_vld valid after edge n (one registered cycle).
- Release latency: owner's req low at edge n clears its grant after edge n. Any handover to the next owner also takes effect after edge n.
- Forced rotation: with other requests pending, the owner holds exactly MAX_HOLD cycles of gnt_vld, then changes owner on the next edge.
- Outputs depend only on registers; there is no combinational path from req to gnt.

## Test plan
- Reset and idle:
  - Stimulus: hold sys_rst_n=0 for 3 cycles with req=8'hFF, then release with req=8'h00.
  - Required: gnt=0, gnt_idx=0, gnt_vld=0 throughout.
  - Then req=8'h01 at edge n: gnt=8'h01, gnt_idx=0, gnt_vld=1 after edge n.
- Round-robin order:
  - Stimulus: req=8'hFF held, each owner drops its req for one cycle after being granted.
  - Required: grant sequence 0,1,2,...,7,0 with no idle cycles between owners.
- Hold limit (MAX_HOLD=16):
  - Stimulus: req=8'h09 held steady.
  - Required: owner 0 holds for exactly 16 cycles, then owner 3 for 16, then back to 0.
  - Stimulus: req=8'h01 alone.
  - Required: owner 0 holds indefinitely and hold_cnt saturates at 15.
- Back-to-back handover and wrap:
  - Stimulus: last_idx=6, owner 6 drops req, req=8'h05.
  - Required: gnt=8'h01 on the next edge (search wraps 7→0), gnt_idx=0, and gnt_vld stays 1 across the handover.
- Reset mid-grant:
  - Stimulus: owner 5 granted, then assert sys_rst_n=0 for one edge with req=8'hFF.
  - Required: all outputs go to 0 at that edge.
  - After release: the next grant goes to requester 0.
- Decoder consistency:
  - Stimulus: random req for 10k cycles.
  - Required: gnt == (gnt_vld ? 1<<gnt_idx : 0) every cycle.
  - Required: no grant to a requester whose req was low.
  - Required: no owner held longer than 16 cycles while another req bit was set.
